uart_rx_char: RTL and testbench

UART_RX_CHAR -- requirements
Module: uart_rx_char

---
 rtl/uart_rx_char.sv | 163 ++++++++++++++++
 tb/tb_uart_rx_char.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_char.sv
// uart_rx_char: 8N1 UART receiver with 16x oversampling.
// The rx line is synchronized, then sampled at mid-bit by a tick-driven FSM.
// A byte is delivered on data with a one-clk en strobe. A bad stop bit raises
// a one-clk frame_err strobe and parks the FSM until the line returns high.
module uart_rx_char #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       en,
  output logic       busy,
  output logic       frame_err
);

  localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_M1 = CW'(DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } state_t;

  logic          rx_meta_r;
  logic          rx_s_r;       // synchronized rx, the only view of the line
  logic [CW-1:0] baud_cnt_r;
  logic          tick_s;
  state_t        state_r, state_nx;
  logic [3:0]    tcnt_r, tcnt_nx;
  logic [2:0]    bidx_r, bidx_nx;
  logic [7:0]    shift_r, shift_nx;
  logic [7:0]    data_r, data_nx;
  logic          en_r, en_nx;
  logic          frame_err_r, frame_err_nx;
  logic          busy_r;

  assign tick_s    = (baud_cnt_r == DIV_M1);
  assign data      = data_r;
  assign en        = en_r;
  assign busy      = busy_r;
  assign frame_err = frame_err_r;

  // Two-flop synchronizer for the asynchronous line; idles high.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_r <= 1'b1;
      rx_s_r    <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_s_r    <= rx_meta_r;
    end
  end

  // Free-running baud tick divider, wraps at DIV-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      baud_cnt_r <= '0;
    end else if (tick_s) begin
      baud_cnt_r <= '0;
    end else begin
      baud_cnt_r <= baud_cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  // Next-state and datapath updates; everything only moves on a baud tick.
  always_comb begin
    state_nx     = state_r;
    tcnt_nx      = tcnt_r;
    bidx_nx      = bidx_r;
    shift_nx     = shift_r;
    data_nx      = data_r;
    en_nx        = 1'b0;
    frame_err_nx = 1'b0;
    if (tick_s) begin
      case (state_r)
        ST_IDLE: begin
          tcnt_nx = 4'd0;
          if (!rx_s_r) state_nx = ST_START;
          else         state_nx = ST_IDLE;
        end
        ST_START: begin
          if (tcnt_r == 4'd7) begin
            tcnt_nx = 4'd0;
            bidx_nx = 3'd0;
            // Line must still be low at mid start bit, otherwise it was a glitch.
            if (!rx_s_r) state_nx = ST_DATA;
            else         state_nx = ST_IDLE;
          end else begin
            tcnt_nx = tcnt_r + 4'd1;
          end
        end
        ST_DATA: begin
          if (tcnt_r == 4'd15) begin
            tcnt_nx          = 4'd0;
            shift_nx[bidx_r] = rx_s_r;
            if (bidx_r == 3'd7) state_nx = ST_STOP;
            else                bidx_nx  = bidx_r + 3'd1;
          end else begin
            tcnt_nx = tcnt_r + 4'd1;
          end
        end
        ST_STOP: begin
          if (tcnt_r == 4'd15) begin
            tcnt_nx = 4'd0;
            if (rx_s_r) begin
              data_nx  = shift_r;
              en_nx    = 1'b1;
              state_nx = ST_IDLE;
            end else begin
              frame_err_nx = 1'b1;
              state_nx     = ST_WAIT_IDLE;
            end
          end else begin
            tcnt_nx = tcnt_r + 4'd1;
          end
        end
        ST_WAIT_IDLE: begin
          // A stuck-low line must not look like a fresh start bit.
          tcnt_nx = 4'd0;
          if (rx_s_r) state_nx = ST_IDLE;
          else        state_nx = ST_WAIT_IDLE;
        end
        default: begin
          state_nx = ST_IDLE;
          tcnt_nx  = 4'd0;
        end
      endcase
    end else begin
      state_nx = state_r;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      tcnt_r      <= 4'd0;
      bidx_r      <= 3'd0;
      shift_r     <= 8'h00;
      data_r      <= 8'h00;
      en_r        <= 1'b0;
      frame_err_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nx;
      tcnt_r      <= tcnt_nx;
      bidx_r      <= bidx_nx;
      shift_r     <= shift_nx;
      data_r      <= data_nx;
      en_r        <= en_nx;
      frame_err_r <= frame_err_nx;
      busy_r      <= (state_nx != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_uart_rx_char.sv
// tb_uart_rx_char: drives 8N1 frames onto rx and compares received bytes,
// strobes and status against a byte-level reference model.
module tb_uart_rx_char;

  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 10_000;
  localparam int BIT_CLK  = 160;
  localparam int LAT_MIN  = 1523;   // 9.5 bits + sync + first tick edge
  localparam int LAT_MAX  = 1532;   // plus one tick period of phase

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] data;
  logic       en;
  logic       busy;
  logic       frame_err;

  uart_rx_char #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(16)) dut (
    .clk(clk), .reset(reset), .rx(rx), .data(data),
    .en(en), .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Observations of the DUT.
  int         cyc = 0;
  logic [7:0] got_q[$];
  int         en_cyc[$];
  int         ferr_cnt = 0;
  int         both_hi = 0;
  int         en_wide = 0;
  int         ferr_wide = 0;
  int         en_busy_hi = 0;
  logic       en_prev = 1'b0;
  logic       ferr_prev = 1'b0;

  // Reference model state.
  logic [7:0] exp_q[$];
  int         exp_ferr = 0;
  logic [7:0] model_data = 8'h00;
  int         last_start = 0;

  // Cycle counter for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor sampled on the falling edge.
  always @(negedge clk) begin
    if (en === 1'b1) begin
      got_q.push_back(data);
      en_cyc.push_back(cyc);
      if (busy !== 1'b0) en_busy_hi++;
    end
    if (frame_err === 1'b1) ferr_cnt++;
    if (en === 1'b1 && frame_err === 1'b1) both_hi++;
    if (en === 1'b1 && en_prev === 1'b1) en_wide++;
    if (frame_err === 1'b1 && ferr_prev === 1'b1) ferr_wide++;
    en_prev   = en;
    ferr_prev = frame_err;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Serializes one 8N1 frame LSB first and updates the model.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    last_start = cyc;
    rx = 1'b0;
    wait_clk(BIT_CLK);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clk(BIT_CLK);
    end
    rx = stop_bit;
    wait_clk(BIT_CLK);
    rx = 1'b1;
    if (stop_bit) begin
      exp_q.push_back(b);
      model_data = b;
    end else begin
      exp_ferr++;
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400; i++) begin
      if (busy === 1'b0) break;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx    = 1'b1;
    wait_clk(4);
    reset = 1'b0;
    wait_clk(2);
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data: got %0h expected 00", data); end
    checks++; if (en !== 1'b0) begin errors++; $display("FAIL reset_en: got %0b expected 0", en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %0b expected 0", frame_err); end
  endtask

  task automatic test_single();
    int base;
    base = exp_q.size();
    send_frame(8'h41, 1'b1);
    wait_idle();
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL single_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    if (got_q.size() > base) begin
      checks++; if (got_q[base] !== 8'h41) begin errors++; $display("FAIL single_byte: got %0h expected 41", got_q[base]); end
      checks++;
      if ((en_cyc[base] - last_start) < LAT_MIN || (en_cyc[base] - last_start) > LAT_MAX) begin
        errors++; $display("FAIL single_latency: got %0d expected %0d..%0d", en_cyc[base] - last_start, LAT_MIN, LAT_MAX);
      end
    end
    checks++; if (ferr_cnt !== exp_ferr) begin errors++; $display("FAIL single_ferr: got %0d expected %0d", ferr_cnt, exp_ferr); end
    checks++; if (data !== model_data) begin errors++; $display("FAIL single_data_hold: got %0h expected %0h", data, model_data); end
    checks++; if (en_busy_hi !== 0) begin errors++; $display("FAIL single_busy_with_en: got %0d expected 0", en_busy_hi); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_idle: got %0b expected 0", busy); end
  endtask

  task automatic test_back_to_back();
    int base;
    logic [7:0] msg [3];
    msg[0] = 8'h54; msg[1] = 8'h45; msg[2] = 8'h0A;
    base = exp_q.size();
    for (int i = 0; i < 3; i++) send_frame(msg[i], 1'b1);
    wait_idle();
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL b2b_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = base; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_byte%0d: got %0h expected %0h", i - base, got_q[i], exp_q[i]); end
    end
    checks++; if (data !== 8'h0A) begin errors++; $display("FAIL b2b_data: got %0h expected 0a", data); end
  endtask

  task automatic test_glitch();
    int n_en;
    n_en = got_q.size();
    rx = 1'b0;
    wait_clk(60);
    rx = 1'b1;
    wait_clk(BIT_CLK);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy: got %0b expected 0", busy); end
    checks++; if (got_q.size() !== n_en) begin errors++; $display("FAIL glitch_en: got %0d expected %0d", got_q.size(), n_en); end
    checks++; if (ferr_cnt !== exp_ferr) begin errors++; $display("FAIL glitch_ferr: got %0d expected %0d", ferr_cnt, exp_ferr); end
    checks++; if (data !== model_data) begin errors++; $display("FAIL glitch_data: got %0h expected %0h", data, model_data); end
  endtask

  task automatic test_frame_err();
    int n_en;
    n_en = got_q.size();
    send_frame(8'h55, 1'b0);
    rx = 1'b0;                 // keep the line broken for 3 more bit times
    wait_clk(3 * BIT_CLK);
    rx = 1'b1;
    wait_clk(BIT_CLK);
    checks++; if (ferr_cnt !== exp_ferr) begin errors++; $display("FAIL ferr_count: got %0d expected %0d", ferr_cnt, exp_ferr); end
    checks++; if (ferr_wide !== 0) begin errors++; $display("FAIL ferr_width: got %0d expected 0", ferr_wide); end
    checks++; if (got_q.size() !== n_en) begin errors++; $display("FAIL ferr_no_en: got %0d expected %0d", got_q.size(), n_en); end
    checks++; if (data !== model_data) begin errors++; $display("FAIL ferr_data_kept: got %0h expected %0h", data, model_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ferr_busy: got %0b expected 0", busy); end
    send_frame(8'h31, 1'b1);
    wait_idle();
    checks++; if (got_q.size() !== n_en + 1) begin errors++; $display("FAIL ferr_recover_count: got %0d expected %0d", got_q.size(), n_en + 1); end
    checks++; if (data !== 8'h31) begin errors++; $display("FAIL ferr_recover_data: got %0h expected 31", data); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    int n_en;
    b = 8'h7E;
    n_en = got_q.size();
    rx = 1'b0;
    wait_clk(BIT_CLK);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      wait_clk(BIT_CLK);
    end
    rx = b[4];
    wait_clk(BIT_CLK / 2);
    reset = 1'b1;
    wait_clk(1);
    reset = 1'b0;
    rx = 1'b1;                 // sender is abandoned along with the frame
    model_data = 8'h00;
    wait_clk(2 * BIT_CLK);
    checks++; if (got_q.size() !== n_en) begin errors++; $display("FAIL rstmid_no_en: got %0d expected %0d", got_q.size(), n_en); end
    checks++; if (ferr_cnt !== exp_ferr) begin errors++; $display("FAIL rstmid_no_ferr: got %0d expected %0d", ferr_cnt, exp_ferr); end
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL rstmid_data: got %0h expected 00", data); end
    send_frame(8'h20, 1'b1);
    wait_idle();
    checks++; if (got_q.size() !== n_en + 1) begin errors++; $display("FAIL rstmid_count: got %0d expected %0d", got_q.size(), n_en + 1); end
    checks++; if (data !== 8'h20) begin errors++; $display("FAIL rstmid_byte: got %0h expected 20", data); end
  endtask

  task automatic test_boundary();
    send_frame(8'hFF, 1'b1);
    wait_idle();
    checks++; if (data !== 8'hFF) begin errors++; $display("FAIL bound_ff: got %0h expected ff", data); end
    send_frame(8'h00, 1'b1);
    wait_idle();
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL bound_00: got %0h expected 00", data); end
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL bound_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
  endtask

  task automatic test_random();
    int base;
    base = exp_q.size();
    for (int n = 0; n < 10; n++) begin
      send_frame(8'($urandom_range(0, 255)), 1'b1);
      wait_clk($urandom_range(0, 300));
    end
    wait_idle();
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = base; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_byte%0d: got %0h expected %0h", i - base, got_q[i], exp_q[i]); end
    end
    checks++; if (data !== model_data) begin errors++; $display("FAIL rand_data_hold: got %0h expected %0h", data, model_data); end
  endtask

  task automatic test_strobe_rules();
    checks++; if (both_hi !== 0) begin errors++; $display("FAIL strobe_exclusive: got %0d expected 0", both_hi); end
    checks++; if (en_wide !== 0) begin errors++; $display("FAIL en_width: got %0d expected 0", en_wide); end
    checks++; if (ferr_cnt !== exp_ferr) begin errors++; $display("FAIL ferr_total: got %0d expected %0d", ferr_cnt, exp_ferr); end
  endtask

  initial begin
    reset = 1'b1;
    rx    = 1'b1;
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid();
    test_boundary();
    test_random();
    test_strobe_rules();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
